// File: rtl/addsub_seq_unit.sv
// Multi-cycle SIMD add/subtract unit, CHUNK bits per cycle.
// Lane modes: word, halfword, byte; optional signed saturation.
module addsub_seq_unit #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter int NCHUNK = WIDTH / CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               op_i,
  input  logic [1:0]         vector_mode_i,
  input  logic               sat_i,
  input  logic               kill_i,
  input  logic [WIDTH-1:0]   operand_a_i,
  input  logic [WIDTH-1:0]   operand_b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic [WIDTH/8-1:0] ovf_o
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] sum_full, res_d;
  logic             op_q, sat_q;
  logic [1:0]       mode_q;
  logic             m8, m16;
  logic [CHUNK-1:0] ach, bch, sch;
  logic             cin, cout, lane_start;
  logic             last;
  logic [NB-1:0]    ovf_b, ovf_d;

  assign ready_o = (state == IDLE);
  assign last    = (cnt == CW'(NCHUNK - 1));
  assign m8      = (mode_q == 2'b10);
  assign m16     = (mode_q == 2'b01);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; kill beats the output handshake.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (valid_i) state_d = BUSY;
      BUSY: begin
        if (kill_i)    state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: if (kill_i || ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the current chunk and decide whether it opens a lane.
  always_comb begin
    ach        = '0;
    bch        = '0;
    lane_start = 1'b0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        ach = a_q[k*CHUNK +: CHUNK];
        bch = b_q[k*CHUNK +: CHUNK];
        lane_start = m8  ? ((k * CHUNK) % 8 == 0)
                   : m16 ? ((k * CHUNK) % 16 == 0)
                   :       (k == 0);
      end
    end
  end

  assign cin = lane_start ? op_q : carry;
  assign {cout, sch} = {1'b0, ach} + {1'b0, bch}
                     + {{CHUNK{1'b0}}, cin};

  // Partial sum with the chunk being computed this cycle merged in.
  always_comb begin
    sum_full = sum_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) sum_full[k*CHUNK +: CHUNK] = sch;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_byte
    localparam int T16 = i | 1;
    localparam int TW  = NB - 1;
    logic       is_top, lo, neg;
    logic [7:0] rb;

    assign ovf_b[i] = (a_q[8*i+7] == b_q[8*i+7])
                   && (sum_full[8*i+7] != a_q[8*i+7]);

    // Locate this byte's lane top and derive saturation value.
    always_comb begin
      is_top = 1'b0;
      lo     = 1'b0;
      neg    = 1'b0;
      unique case (1'b1)
        m8: begin
          is_top = 1'b1;
          lo     = ovf_b[i];
          neg    = a_q[8*i+7];
        end
        m16: begin
          is_top = (i == T16);
          lo     = ovf_b[T16];
          neg    = a_q[8*T16+7];
        end
        default: begin
          is_top = (i == TW);
          lo     = ovf_b[TW];
          neg    = a_q[8*TW+7];
        end
      endcase
      rb = sum_full[8*i +: 8];
      if (sat_q && lo) begin
        if (is_top) rb = {neg, {7{~neg}}};
        else        rb = {8{~neg}};
      end
    end

    assign ovf_d[i]          = is_top & lo;
    assign res_d[8*i +: 8]   = rb;
  end

  // Operand capture, chunked carry chain and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      op_q     <= 1'b0;
      sat_q    <= 1'b0;
      mode_q   <= 2'b00;
      result_o <= '0;
      ovf_o    <= '0;
      valid_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            a_q    <= operand_a_i;
            b_q    <= op_i ? ~operand_b_i : operand_b_i;
            op_q   <= op_i;
            sat_q  <= sat_i;
            mode_q <= vector_mode_i;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
          end
        end
        BUSY: begin
          if (kill_i) begin
            cnt <= '0;
          end else begin
            sum_q <= sum_full;
            carry <= cout;
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
              result_o <= res_d;
              ovf_o    <= ovf_d;
              valid_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (kill_i || ready_i) valid_o <= 1'b0;
          if (kill_i) cnt <= '0;
        end
        default: valid_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Bench for addsub_seq_unit: directed cases plus random
// operations against a lane-arithmetic reference model.
module tb_addsub_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, op_i, sat_i, kill_i;
  logic [1:0]  vector_mode_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        valid_o, ready_i;
  logic [31:0] result_o;
  logic [3:0]  ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  addsub_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .vector_mode_i (vector_mode_i),
    .sat_i         (sat_i),
    .kill_i        (kill_i),
    .operand_a_i   (operand_a_i),
    .operand_b_i   (operand_b_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signed lane arithmetic with range check, independent of carries.
  function automatic void model(input logic [31:0] a, b,
                                input logic op,
                                input logic [1:0] mode,
                                input logic sat,
                                output logic [31:0] r,
                                output logic [3:0] ov);
    int lw;
    longint m, h, ua, ub, sa, sb, s, rv;
    bit o;
    lw = (mode == 2'b01) ? 16 : (mode == 2'b10) ? 8 : 32;
    m  = (longint'(1) << lw) - 1;
    h  = longint'(1) << (lw - 1);
    r  = '0;
    ov = '0;
    for (int l = 0; l < 32 / lw; l++) begin
      ua = (longint'(a) >> (l * lw)) & m;
      ub = (longint'(b) >> (l * lw)) & m;
      sa = (ua >= h) ? ua - (m + 1) : ua;
      sb = (ub >= h) ? ub - (m + 1) : ub;
      s  = op ? sa - sb : sa + sb;
      o  = (s >= h) || (s < -h);
      rv = (sat && o) ? ((s > 0) ? h - 1 : -h) : s;
      r  = r | 32'((rv & m) << (l * lw));
      ov[((l + 1) * lw) / 8 - 1] = o;
    end
  endfunction

  task automatic scramble();
    operand_a_i   = $urandom;
    operand_b_i   = $urandom;
    op_i          = 1'($urandom);
    sat_i         = 1'($urandom);
    vector_mode_i = 2'($urandom);
  endtask

  // Called at a negedge with the unit idle; returns at a negedge.
  task automatic run_op(input logic [31:0] a, b,
                        input logic op,
                        input logic [1:0] mode,
                        input logic sat,
                        input logic [31:0] er,
                        input logic [3:0] eo,
                        input int hold);
    int lat;
    bit rdy_busy;
    chk("ready_idle", 64'(ready_o), 64'(1));
    operand_a_i   = a;
    operand_b_i   = b;
    op_i          = op;
    vector_mode_i = mode;
    sat_i         = sat;
    valid_i       = 1'b1;
    @(negedge clk);
    valid_i  = 1'b0;
    lat      = 0;
    rdy_busy = 0;
    while (!valid_o && lat < 20) begin
      if (ready_o) rdy_busy = 1;
      scramble();
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(4));
    chk("ready_busy", 64'(rdy_busy), 64'(0));
    chk("result", 64'(result_o), 64'(er));
    chk("ovf", 64'(ovf_o), 64'(eo));
    for (int h = 0; h < hold; h++) begin
      scramble();
      @(negedge clk);
      chk("hold_valid", 64'(valid_o), 64'(1));
      chk("hold_result", 64'(result_o), 64'(er));
      chk("hold_ovf", 64'(ovf_o), 64'(eo));
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("valid_drop", 64'(valid_o), 64'(0));
    chk("result_keep", 64'(result_o), 64'(er));
    chk("ovf_keep", 64'(ovf_o), 64'(eo));
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [1:0]  mode;
    logic        sat;
    logic [31:0] er;
    logic [3:0]  eo;
    int          hold;
  } vec_t;

  vec_t dir[$];

  initial begin
    logic [31:0] mr;
    logic [3:0]  mo;
    bit seen;

    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    kill_i  = 1'b0;
    operand_a_i = '0;
    operand_b_i = '0;
    op_i = 1'b0;
    sat_i = 1'b0;
    vector_mode_i = 2'b00;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'(1));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_ovf", 64'(ovf_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    dir.push_back('{32'd10, 32'd30, 1'b0, 2'b00, 1'b0,
                    32'd40, 4'b0000, 0});
    dir.push_back('{32'd1, 32'd10, 1'b1, 2'b00, 1'b0,
                    32'hFFFF_FFF7, 4'b0000, 0});
    dir.push_back('{32'h8000_0000, 32'd1, 1'b1, 2'b00, 1'b1,
                    32'h8000_0000, 4'b1000, 0});
    dir.push_back('{32'h7FFF_0001, 32'h0001_0001, 1'b0, 2'b01, 1'b1,
                    32'h7FFF_0002, 4'b1000, 0});
    dir.push_back('{32'h7FFF_0001, 32'h0001_0001, 1'b0, 2'b01, 1'b0,
                    32'h8000_0002, 4'b1000, 0});
    dir.push_back('{32'h0080_7F05, 32'h0101_0101, 1'b1, 2'b10, 1'b1,
                    32'hFF80_7E04, 4'b0100, 0});
    dir.push_back('{32'h0080_7F05, 32'h0101_0101, 1'b1, 2'b10, 1'b0,
                    32'hFF7F_7E04, 4'b0100, 3});
    dir.push_back('{32'h7FFF_FFFF, 32'd1, 1'b0, 2'b11, 1'b1,
                    32'h7FFF_FFFF, 4'b1000, 0});
    dir.push_back('{32'hFFFF_FFFF, 32'd1, 1'b0, 2'b00, 1'b1,
                    32'h0000_0000, 4'b0000, 0});

    foreach (dir[i])
      run_op(dir[i].a, dir[i].b, dir[i].op, dir[i].mode,
             dir[i].sat, dir[i].er, dir[i].eo, dir[i].hold);

    // Kill on the second busy cycle.
    operand_a_i = 32'd5;
    operand_b_i = 32'd6;
    op_i = 1'b0;
    vector_mode_i = 2'b00;
    sat_i = 1'b0;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_idle", 64'(ready_o), 64'(1));
    seen = 0;
    repeat (8) begin
      if (valid_o) seen = 1;
      @(negedge clk);
    end
    chk("kill_novalid", 64'(seen), 64'(0));

    // Asynchronous reset in the middle of an operation.
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_result", 64'(result_o), 64'(0));
    chk("arst_ovf", 64'(ovf_o), 64'(0));
    chk("arst_valid", 64'(valid_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'd10, 32'd30, 1'b0, 2'b00, 1'b0, 32'd40, 4'b0000, 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra, rb;
      logic        rop, rsat;
      logic [1:0]  rmode;
      ra    = $urandom;
      rb    = $urandom;
      rop   = 1'($urandom);
      rsat  = 1'($urandom);
      rmode = 2'($urandom);
      if (n % 5 == 0) begin
        ra = {4{8'h7F ^ 8'($urandom_range(0, 1))}};
        rb = {4{8'h80 | 8'($urandom_range(0, 1))}};
      end
      model(ra, rb, rop, rmode, rsat, mr, mo);
      run_op(ra, rb, rop, rmode, rsat, mr, mo,
             $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
